// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared mode constants and channel-index helpers for the bus mux
package bus_pkg;

    localparam logic MODE_SELECT = 1'b0;
    localparam logic MODE_RR     = 1'b1;
    localparam int   MAX_CHAN    = 16;

    typedef logic [$clog2(MAX_CHAN)-1:0] chan_idx_t;

    // Channel-index width for n channels; never narrower than one bit.
    function automatic int chan_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant starting the search at PTR
module rr_arbiter
    import bus_pkg::*;
#(
    parameter int N    = 3,
    parameter int SELW = chan_w(N)
) (
    input  logic [N-1:0]    REQ,
    input  logic [SELW-1:0] PTR,
    output logic [N-1:0]    GNT,
    output logic [SELW-1:0] IDX,
    output logic            VALID
);

    logic found;

    // Offset k from PTR is tried in order; the first requesting channel wins.
    always_comb begin
        found = 1'b0;
        GNT   = '0;
        IDX   = '0;
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!found && REQ[i] && (i == (int'(PTR) + k) % N)) begin
                    found  = 1'b1;
                    GNT[i] = 1'b1;
                    IDX    = SELW'(i);
                end
            end
        end
    end

    assign VALID = found;

endmodule

// File: rtl/buffer_mux_arb.sv
// rtl/buffer_mux_arb.sv - N-way valid/ready bus mux with external-select or round-robin grant
module buffer_mux_arb
    import bus_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N     = 3,
    parameter int SELW  = chan_w(N)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               MODE,
    input  logic [SELW-1:0]    SEL,
    input  logic [N*WIDTH-1:0] IN_DATA,
    input  logic [N-1:0]       IN_VALID,
    output logic [N-1:0]       IN_READY,
    output logic [WIDTH-1:0]   OUT_DATA,
    output logic               OUT_VALID,
    input  logic               OUT_READY,
    output logic [SELW-1:0]    OUT_CHAN,
    output logic               SEL_ERR
);

    logic             load_en;
    logic             sel_ok;
    logic [N-1:0]     sel_gnt;
    logic [N-1:0]     rr_gnt;
    logic [SELW-1:0]  rr_idx;
    logic             rr_valid;
    logic [SELW-1:0]  ptr;
    logic [N-1:0]     grant_vec;
    logic [SELW-1:0]  grant_idx;
    logic             grant_valid;
    logic [WIDTH-1:0] grant_data;

    assign load_en = !OUT_VALID || OUT_READY;
    assign sel_ok  = int'(SEL) < N;

    always_comb begin
        sel_gnt = '0;
        for (int i = 0; i < N; i++) begin
            if (sel_ok && (int'(SEL) == i) && IN_VALID[i]) begin
                sel_gnt[i] = 1'b1;
            end
        end
    end

    rr_arbiter #(.N(N), .SELW(SELW)) u_rr (
        .REQ   (IN_VALID),
        .PTR   (ptr),
        .GNT   (rr_gnt),
        .IDX   (rr_idx),
        .VALID (rr_valid)
    );

    assign grant_vec   = (MODE == MODE_RR) ? rr_gnt   : sel_gnt;
    assign grant_idx   = (MODE == MODE_RR) ? rr_idx   : SEL;
    assign grant_valid = (MODE == MODE_RR) ? rr_valid : |sel_gnt;

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_vec[i]) begin
                grant_data = IN_DATA[i*WIDTH +: WIDTH];
            end
        end
    end

    assign IN_READY = (load_en && !RST) ? grant_vec : '0;

    always_ff @(posedge CLK) begin
        if (RST) begin
            OUT_VALID <= 1'b0;
            OUT_DATA  <= '0;
            OUT_CHAN  <= '0;
            SEL_ERR   <= 1'b0;
            ptr       <= '0;
        end else begin
            if ((MODE == MODE_SELECT) && !sel_ok) begin
                SEL_ERR <= 1'b1;
            end
            // An empty slot or a consumed word with nothing granted leaves the register empty.
            if (load_en) begin
                if (grant_valid) begin
                    OUT_DATA  <= grant_data;
                    OUT_CHAN  <= grant_idx;
                    OUT_VALID <= 1'b1;
                    if (MODE == MODE_RR) begin
                        ptr <= (grant_idx == SELW'(N - 1)) ? '0 : grant_idx + 1'b1;
                    end
                end else begin
                    OUT_VALID <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_buffer_mux_arb.sv
// tb/tb_buffer_mux_arb.sv - self-checking bench for buffer_mux_arb with a behavioural model
module tb_buffer_mux_arb;
    localparam int WIDTH = 32;
    localparam int N     = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              mode;
    logic [1:0]        sel;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]      in_valid;
    logic [N-1:0]      in_ready;
    logic [WIDTH-1:0]  out_data;
    logic              out_valid;
    logic              out_ready;
    logic [1:0]        out_chan;
    logic              sel_err;

    int checks = 0;
    int errors = 0;

    logic              m_ov;
    logic [WIDTH-1:0]  m_od;
    int                m_oc;
    logic              m_err;
    int                m_ptr;

    buffer_mux_arb #(.WIDTH(WIDTH), .N(N)) dut (
        .CLK       (clk),
        .RST       (rst),
        .MODE      (mode),
        .SEL       (sel),
        .IN_DATA   (in_data),
        .IN_VALID  (in_valid),
        .IN_READY  (in_ready),
        .OUT_DATA  (out_data),
        .OUT_VALID (out_valid),
        .OUT_READY (out_ready),
        .OUT_CHAN  (out_chan),
        .SEL_ERR   (sel_err)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] chan_data(input int c);
        return in_data[c*WIDTH +: WIDTH];
    endfunction

    // Channel the rules award this cycle, or -1 for none.
    function automatic int grant_of();
        if (mode == 1'b0) begin
            if (int'(sel) < N && in_valid[sel]) return int'(sel);
            return -1;
        end
        for (int k = 0; k < N; k++) begin
            if (in_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        int g;
        g = grant_of();
        if (rst || !(!m_ov || out_ready) || g < 0) return '0;
        return N'(1) << g;
    endfunction

    task automatic tick();
        int g;
        logic ld;
        logic [WIDTH-1:0] d;
        g  = grant_of();
        ld = !m_ov || out_ready;
        d  = (g >= 0) ? chan_data(g) : '0;
        @(posedge clk);
        if (rst) begin
            m_ov = 0; m_od = '0; m_oc = 0; m_err = 0; m_ptr = 0;
        end else begin
            if (mode == 1'b0 && int'(sel) >= N) m_err = 1;
            if (ld) begin
                if (g >= 0) begin
                    m_od = d; m_oc = g; m_ov = 1;
                    if (mode) m_ptr = (g + 1) % N;
                end else begin
                    m_ov = 0;
                end
            end
        end
        #1;
    endtask

    task automatic set_data(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic [WIDTH-1:0] c);
        in_data = {c, b, a};
    endtask

    task automatic test_reset();
        rst = 1; mode = 0; sel = 0; in_valid = 3'b111; out_ready = 1;
        set_data(32'h1, 32'h2, 32'h3);
        #1;
        checks++;
        if (in_ready !== 3'b000) begin
            errors++; $display("FAIL reset_ready: got %b expected 000", in_ready);
        end
        tick(); tick();
        checks++;
        if ({out_valid, out_data, out_chan, sel_err} !== {1'b0, 32'h0, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got v=%b d=%h c=%0d e=%b expected all zero",
                     out_valid, out_data, out_chan, sel_err);
        end
        rst = 0;
    endtask

    task automatic test_select();
        mode = 0; sel = 1; in_valid = 3'b111; out_ready = 1;
        set_data(32'h11, 32'h22, 32'h33);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (in_ready !== 3'b010) begin
                errors++; $display("FAIL select_ready: got %b expected 010", in_ready);
            end
            tick();
            checks++;
            if ({out_valid, out_data, out_chan} !== {1'b1, 32'h22, 2'd1}) begin
                errors++;
                $display("FAIL select_out: got v=%b d=%h c=%0d expected v=1 d=22 c=1",
                         out_valid, out_data, out_chan);
            end
        end
    endtask

    task automatic test_round_robin();
        int exp_seq[6] = '{0, 1, 2, 0, 1, 2};
        mode = 1; in_valid = 3'b111; out_ready = 1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (out_chan !== 2'(exp_seq[i]) || out_data !== chan_data(exp_seq[i])) begin
                errors++;
                $display("FAIL rr_seq[%0d]: got c=%0d d=%h expected c=%0d", i, out_chan,
                         out_data, exp_seq[i]);
            end
        end
    endtask

    task automatic test_rr_skip();
        int exp_seq[4] = '{2, 0, 2, 0};
        mode = 1; in_valid = 3'b001; out_ready = 1;
        tick();
        in_valid = 3'b101;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (in_ready[1] !== 1'b0 || in_ready !== exp_ready()) begin
                errors++; $display("FAIL rr_skip_ready[%0d]: got %b expected %b", i, in_ready,
                                   exp_ready());
            end
            tick();
            checks++;
            if (out_chan !== 2'(exp_seq[i])) begin
                errors++; $display("FAIL rr_skip_chan[%0d]: got %0d expected %0d", i, out_chan,
                                   exp_seq[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        mode = 0; sel = 1; in_valid = 3'b111; out_ready = 1;
        set_data(32'h11, 32'h22, 32'h33);
        tick();
        out_ready = 0;
        set_data(32'h11, 32'h44, 32'h33);
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (in_ready !== 3'b000) begin
                errors++; $display("FAIL stall_ready[%0d]: got %b expected 000", i, in_ready);
            end
            tick();
            checks++;
            if ({out_valid, out_data, out_chan} !== {1'b1, 32'h22, 2'd1}) begin
                errors++; $display("FAIL stall_hold[%0d]: got v=%b d=%h expected v=1 d=22", i,
                                   out_valid, out_data);
            end
        end
        out_ready = 1;
        #1;
        checks++;
        if (in_ready !== 3'b010) begin
            errors++; $display("FAIL release_ready: got %b expected 010", in_ready);
        end
        tick();
        checks++;
        if ({out_valid, out_data} !== {1'b1, 32'h44}) begin
            errors++; $display("FAIL release_reload: got v=%b d=%h expected v=1 d=44",
                               out_valid, out_data);
        end
    endtask

    task automatic test_sel_err();
        mode = 0; sel = 3; in_valid = 3'b111; out_ready = 1;
        #1;
        checks++;
        if (in_ready !== 3'b000) begin
            errors++; $display("FAIL selerr_ready: got %b expected 000", in_ready);
        end
        tick();
        checks++;
        if ({out_valid, sel_err} !== 2'b01) begin
            errors++; $display("FAIL selerr_drain: got v=%b e=%b expected v=0 e=1",
                               out_valid, sel_err);
        end
        sel = 0;
        tick();
        checks++;
        if ({out_valid, out_chan, sel_err} !== {1'b1, 2'd0, 1'b1}) begin
            errors++; $display("FAIL selerr_sticky: got v=%b c=%0d e=%b expected v=1 c=0 e=1",
                               out_valid, out_chan, sel_err);
        end
    endtask

    task automatic test_reset_midstream();
        mode = 1; in_valid = 3'b111; out_ready = 1;
        tick();
        rst = 1;
        #1;
        checks++;
        if (in_ready !== 3'b000) begin
            errors++; $display("FAIL rst_mid_ready: got %b expected 000", in_ready);
        end
        tick();
        rst = 0;
        checks++;
        if ({out_valid, out_data, sel_err} !== {1'b0, 32'h0, 1'b0}) begin
            errors++; $display("FAIL rst_mid_state: got v=%b d=%h e=%b expected zeros",
                               out_valid, out_data, sel_err);
        end
        tick();
        checks++;
        if ({out_valid, out_chan} !== {1'b1, 2'd0}) begin
            errors++; $display("FAIL rst_mid_rr: got v=%b c=%0d expected v=1 c=0",
                               out_valid, out_chan);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom_range(0, 39) == 0);
            mode      = 1'($urandom_range(0, 1));
            sel       = ($urandom_range(0, 19) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            in_valid  = 3'($urandom_range(0, 7));
            out_ready = ($urandom_range(0, 3) != 0);
            set_data($urandom, $urandom, $urandom);
            #1;
            checks++;
            if (in_ready !== exp_ready()) begin
                errors++; $display("FAIL rand_ready[%0d]: got %b expected %b", i, in_ready,
                                   exp_ready());
            end
            tick();
            checks++;
            if ({out_valid, out_data, out_chan, sel_err} !== {m_ov, m_od, 2'(m_oc), m_err}) begin
                errors++;
                $display("FAIL rand_out[%0d]: got v=%b d=%h c=%0d e=%b expected v=%b d=%h c=%0d e=%b",
                         i, out_valid, out_data, out_chan, sel_err, m_ov, m_od, m_oc, m_err);
            end
            checks++;
            if (int'(out_chan) >= N) begin
                errors++; $display("FAIL rand_chan_range[%0d]: got %0d expected <3", i, out_chan);
            end
        end
        rst = 0;
    endtask

    initial begin
        m_ov = 0; m_od = '0; m_oc = 0; m_err = 0; m_ptr = 0;
        test_reset();
        test_select();
        test_round_robin();
        test_rr_skip();
        test_backpressure();
        test_sel_err();
        test_reset_midstream();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
